// File: rtl/caddsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : caddsub_pipe
//  Purpose  : Pipelined complex adder/subtractor with valid/ready flow
//             control, per-sample operation select and optional saturation
//             to the input width with a sticky overflow flag.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SIZEIN   width of each signed input component
//    LATENCY  register stages from input acceptance to out_valid (2..8)
//    SAT      0 = SIZEIN+1 bit full-precision results,
//             1 = results clamped to SIZEIN bits
//  Ports
//    clk, rst          clock, asynchronous active-high reset
//    ce                global clock enable (0 freezes every register)
//    in_valid/in_ready input handshake
//    op                00 a-b | 01 a+b | 10 b-a | 11 a-conj(b)
//    ar, ai, br, bi    signed operands a = ar + j*ai, b = br + j*bi
//    out_valid/out_ready output handshake
//    sr, si            signed result (SIZEOUT bits)
//    ovf, ovf_clr      sticky clamp flag and its synchronous clear
// ============================================================================
module caddsub_pipe #(
    parameter  int SIZEIN  = 16,
    parameter  int LATENCY = 2,
    parameter  int SAT     = 0,
    localparam int SIZEOUT = (SAT != 0) ? SIZEIN : SIZEIN + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                op,
    input  logic signed [SIZEIN-1:0]  ar,
    input  logic signed [SIZEIN-1:0]  ai,
    input  logic signed [SIZEIN-1:0]  br,
    input  logic signed [SIZEIN-1:0]  bi,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [SIZEOUT-1:0] sr,
    output logic signed [SIZEOUT-1:0] si,
    output logic                      ovf,
    input  logic                      ovf_clr
);

    localparam int W    = SIZEIN + 1;   // internal width, cannot overflow
    localparam int NPRE = LATENCY - 1;  // stages ahead of the output register

    logic                      stall_w;
    logic                      adv_w;
    logic signed [W-1:0]       ar_w, ai_w, br_w, bi_w;
    logic signed [W-1:0]       s1r_d, s1i_d;
    logic signed [W-1:0]       pr_q [1:NPRE];
    logic signed [W-1:0]       pi_q [1:NPRE];
    logic [NPRE:1]             vld_q;
    logic signed [W-1:0]       fr_w, fi_w;
    logic signed [SIZEOUT-1:0] sr_d, si_d, sr_q, si_q;
    logic                      clamp_d, clamp_q;
    logic                      out_valid_q;
    logic                      ovf_d, ovf_q;

    // The whole pipeline moves as one: it only freezes when the result at
    // the output has not been taken, so bubbles never need to be accepted.
    assign stall_w  = out_valid_q && !out_ready;
    assign adv_w    = ce && !stall_w;
    assign in_ready = adv_w && !rst;

    assign ar_w = {ar[SIZEIN-1], ar};
    assign ai_w = {ai[SIZEIN-1], ai};
    assign br_w = {br[SIZEIN-1], br};
    assign bi_w = {bi[SIZEIN-1], bi};

    // Stage 1 arithmetic
    always_comb begin
        s1r_d = ar_w - br_w;
        s1i_d = ai_w - bi_w;
        case (op)
            2'b00: begin s1r_d = ar_w - br_w; s1i_d = ai_w - bi_w; end
            2'b01: begin s1r_d = ar_w + br_w; s1i_d = ai_w + bi_w; end
            2'b10: begin s1r_d = br_w - ar_w; s1i_d = bi_w - ai_w; end
            default: begin s1r_d = ar_w - br_w; s1i_d = ai_w + bi_w; end
        endcase
    end

    // Stage 1 plus pure delay stages up to the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= NPRE; k++) begin
                pr_q[k] <= '0;
                pi_q[k] <= '0;
            end
            vld_q <= '0;
        end else if (adv_w) begin
            pr_q[1]  <= s1r_d;
            pi_q[1]  <= s1i_d;
            vld_q[1] <= in_valid;
            for (int k = 2; k <= NPRE; k++) begin
                pr_q[k]  <= pr_q[k-1];
                pi_q[k]  <= pi_q[k-1];
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    assign fr_w = pr_q[NPRE];
    assign fi_w = pi_q[NPRE];

    // Final stage: optional clamp into SIZEIN bits
    generate
        if (SAT != 0) begin : g_sat
            localparam logic signed [SIZEOUT-1:0] C_MAX = {1'b0, {(SIZEOUT-1){1'b1}}};
            localparam logic signed [SIZEOUT-1:0] C_MIN = {1'b1, {(SIZEOUT-1){1'b0}}};
            logic cr_w, ci_w;
            // The value leaves the SIZEIN-bit range exactly when the two top
            // bits of the (SIZEIN+1)-bit result disagree; the top bit is the
            // true sign and selects which rail to clamp to.
            assign cr_w    = fr_w[W-1] ^ fr_w[W-2];
            assign ci_w    = fi_w[W-1] ^ fi_w[W-2];
            assign sr_d    = cr_w ? (fr_w[W-1] ? C_MIN : C_MAX) : fr_w[SIZEIN-1:0];
            assign si_d    = ci_w ? (fi_w[W-1] ? C_MIN : C_MAX) : fi_w[SIZEIN-1:0];
            assign clamp_d = cr_w | ci_w;
        end else begin : g_full
            assign sr_d    = fr_w;
            assign si_d    = fi_w;
            assign clamp_d = 1'b0;
        end
    endgenerate

    // Sticky flag: set by the transfer of a clamped result; a set in the
    // same cycle as a clear wins. Gated by ce like every other register.
    always_comb begin
        ovf_d = ovf_q;
        if (ce) begin
            if (ovf_clr) begin
                ovf_d = 1'b0;
            end
            if (out_valid_q && out_ready && clamp_q) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sr_q        <= '0;
            si_q        <= '0;
            clamp_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (adv_w) begin
                out_valid_q <= vld_q[NPRE];
                sr_q        <= sr_d;
                si_q        <= si_d;
                clamp_q     <= clamp_d;
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sr        = sr_q;
    assign si        = si_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_caddsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_caddsub_pipe
//  Purpose  : Self-checking bench for caddsub_pipe. Two instances share the
//             control inputs: dut0 (LATENCY=2, SAT=0) and dut1 (LATENCY=4,
//             SAT=1). Each has its own input handshake and operands.
//  Revision : 1.0  initial release
// ============================================================================
module tb_caddsub_pipe;

    logic clk = 1'b0;
    logic rst, ce, out_ready, ovf_clr;
    logic                in_valid [2];
    logic [1:0]          op       [2];
    logic signed [15:0]  ar [2], ai [2], br [2], bi [2];
    logic                ir0, ir1, ov0, ov1, of0, of1;
    logic signed [16:0]  sr0, si0;
    logic signed [15:0]  sr1, si1;
    logic                in_ready_a [2], out_valid_a [2], ovf_a [2];
    int                  osr [2], osi [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    caddsub_pipe #(.SIZEIN(16), .LATENCY(2), .SAT(0)) dut0 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid[0]), .in_ready(ir0),
        .op(op[0]), .ar(ar[0]), .ai(ai[0]), .br(br[0]), .bi(bi[0]),
        .out_valid(ov0), .out_ready(out_ready), .sr(sr0), .si(si0),
        .ovf(of0), .ovf_clr(ovf_clr));

    caddsub_pipe #(.SIZEIN(16), .LATENCY(4), .SAT(1)) dut1 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid[1]), .in_ready(ir1),
        .op(op[1]), .ar(ar[1]), .ai(ai[1]), .br(br[1]), .bi(bi[1]),
        .out_valid(ov1), .out_ready(out_ready), .sr(sr1), .si(si1),
        .ovf(of1), .ovf_clr(ovf_clr));

    always_comb begin
        in_ready_a[0] = ir0;  in_ready_a[1] = ir1;
        out_valid_a[0] = ov0; out_valid_a[1] = ov1;
        ovf_a[0] = of0;       ovf_a[1] = of1;
        osr[0] = int'(sr0);   osi[0] = int'(si0);
        osr[1] = int'(sr1);   osi[1] = int'(si1);
    end

    task automatic chk(int d, string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d, want %0d (t=%0t)", nm, d, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: complex arithmetic on plain integers, clamped to
    // 16-bit range for the saturating instance.
    // ------------------------------------------------------------------
    typedef struct {
        int sr;
        int si;
        bit clamp;
    } exp_t;

    function automatic exp_t model(int d, logic [1:0] o, int a_r, int a_i, int b_r, int b_i);
        exp_t e;
        int r, i;
        case (o)
            2'd0:    begin r = a_r - b_r; i = a_i - b_i; end
            2'd1:    begin r = a_r + b_r; i = a_i + b_i; end
            2'd2:    begin r = b_r - a_r; i = b_i - a_i; end
            default: begin r = a_r - b_r; i = a_i + b_i; end
        endcase
        e.clamp = 1'b0;
        if (d == 1) begin
            if (r > 32767)  begin r = 32767;  e.clamp = 1'b1; end
            if (r < -32768) begin r = -32768; e.clamp = 1'b1; end
            if (i > 32767)  begin i = 32767;  e.clamp = 1'b1; end
            if (i < -32768) begin i = -32768; e.clamp = 1'b1; end
        end
        e.sr = r;
        e.si = i;
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard monitor: samples on the falling edge, pushes the model
    // result for every accepted input and compares every output transfer
    // in order. Also tracks the expected sticky flag.
    // ------------------------------------------------------------------
    exp_t ring [2][64];
    int   wr [2] = '{0, 0};
    int   rd [2] = '{0, 0};
    bit   movf [2] = '{1'b0, 1'b0};
    int   out_cnt [2] = '{0, 0};

    always @(negedge clk) begin : mon
        exp_t e;
        bit   nx, xfer;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                wr[d] = 0; rd[d] = 0; movf[d] = 1'b0;
                chk(d, "rst_in_ready", int'(in_ready_a[d]), 0);
                chk(d, "rst_out_valid", int'(out_valid_a[d]), 0);
            end else begin
                chk(d, "in_ready", int'(in_ready_a[d]),
                    int'(ce && !(out_valid_a[d] && !out_ready)));
                chk(d, "ovf", int'(ovf_a[d]), int'(movf[d]));
                if (in_valid[d] && in_ready_a[d]) begin
                    ring[d][wr[d] % 64] = model(d, op[d], ar[d], ai[d], br[d], bi[d]);
                    wr[d]++;
                end
                // ce=0 freezes the block, so a held result is not consumed.
                xfer = out_valid_a[d] && out_ready && ce;
                nx = movf[d];
                if (ce && ovf_clr) nx = 1'b0;
                if (xfer) begin
                    out_cnt[d]++;
                    chk(d, "out_has_pending", int'(wr[d] != rd[d]), 1);
                    if (wr[d] != rd[d]) begin
                        e = ring[d][rd[d] % 64];
                        rd[d]++;
                        chk(d, "sb_sr", osr[d], e.sr);
                        chk(d, "sb_si", osi[d], e.si);
                        if (e.clamp) nx = 1'b1;
                    end
                end
                movf[d] = nx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0]         op;
        logic signed [15:0] ar, ai, br, bi;
        int                 sr0, si0, sr1, si1, ovf1;
    } vec_t;

    function automatic vec_t mk(logic [1:0] o, int a_r, int a_i, int b_r, int b_i,
                                int e0r, int e0i, int e1r, int e1i, int ov);
        vec_t v;
        v.op = o;
        v.ar = 16'(a_r); v.ai = 16'(a_i); v.br = 16'(b_r); v.bi = 16'(b_i);
        v.sr0 = e0r; v.si0 = e0i; v.sr1 = e1r; v.si1 = e1i; v.ovf1 = ov;
        return v;
    endfunction

    task automatic drive(int d, logic v, logic [1:0] o, logic signed [15:0] a_r,
                         logic signed [15:0] a_i, logic signed [15:0] b_r, logic signed [15:0] b_i);
        in_valid[d] = v; op[d] = o;
        ar[d] = a_r; ai[d] = a_i; br[d] = b_r; bi[d] = b_i;
    endtask

    task automatic idle_inputs();
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
    endtask

    task automatic apply_vec(vec_t v);
        @(posedge clk); #1;
        ovf_clr = 1'b1; idle_inputs();
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        for (int d = 0; d < 2; d++) drive(d, 1'b1, v.op, v.ar, v.ai, v.br, v.bi);
        @(posedge clk); #1;                      // accepted at this edge (N)
        idle_inputs();
        @(negedge clk);
        chk(0, "lat_not_early", int'(ov0), 0);
        @(posedge clk); @(negedge clk);          // after N+1
        chk(0, "vec_valid", int'(ov0), 1);
        chk(0, "vec_sr", osr[0], v.sr0);
        chk(0, "vec_si", osi[0], v.si0);
        chk(1, "lat_not_early", int'(ov1), 0);
        @(posedge clk); @(negedge clk);          // after N+2
        chk(0, "no_duplicate", int'(ov0), 0);
        @(posedge clk); @(negedge clk);          // after N+3
        chk(1, "vec_valid", int'(ov1), 1);
        chk(1, "vec_sr", osr[1], v.sr1);
        chk(1, "vec_si", osi[1], v.si1);
        @(posedge clk); @(negedge clk);          // after N+4
        chk(1, "vec_ovf", int'(of1), v.ovf1);
        chk(1, "no_duplicate", int'(ov1), 0);
    endtask

    // ------------------------------------------------------------------
    // Stream of n samples with op cycling 00..11; out_ready low for cycles
    // st_lo..st_hi and ce low for cycles ce_lo..ce_hi (relative counter).
    // ------------------------------------------------------------------
    bit saw_stall;

    task automatic stream(int n, int st_lo, int st_hi, int ce_lo, int ce_hi);
        logic [1:0]         so  [16];
        logic signed [15:0] sar [16], sai [16], sbr [16], sbi [16];
        int idx [2];
        int c0 [2];
        int c;
        bit prev_ce;
        int snap_v [2], snap_r [2], snap_i [2];
        for (int k = 0; k < 16; k++) begin
            so[k]  = 2'(k % 4);
            sar[k] = 16'($urandom); sai[k] = 16'($urandom);
            sbr[k] = 16'($urandom); sbi[k] = 16'($urandom);
        end
        idx = '{0, 0};
        c0[0] = out_cnt[0]; c0[1] = out_cnt[1];
        c = 0;
        prev_ce = 1'b1;
        saw_stall = 1'b0;
        while ((out_cnt[0] - c0[0] < n || out_cnt[1] - c0[1] < n) && c < 200) begin
            @(posedge clk); #1;
            out_ready = !(c >= st_lo && c <= st_hi);
            ce        = !(c >= ce_lo && c <= ce_hi);
            for (int d = 0; d < 2; d++) begin
                if (idx[d] < n)
                    drive(d, 1'b1, so[idx[d]], sar[idx[d]], sai[idx[d]], sbr[idx[d]], sbi[idx[d]]);
                else
                    in_valid[d] = 1'b0;
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!prev_ce) begin
                    chk(d, "ce_hold_valid", int'(out_valid_a[d]), snap_v[d]);
                    chk(d, "ce_hold_sr", osr[d], snap_r[d]);
                    chk(d, "ce_hold_si", osi[d], snap_i[d]);
                end
                snap_v[d] = int'(out_valid_a[d]);
                snap_r[d] = osr[d];
                snap_i[d] = osi[d];
                if (in_valid[d] && in_ready_a[d]) idx[d]++;
            end
            if (ce && out_valid_a[0] && !out_ready && !in_ready_a[0]) saw_stall = 1'b1;
            prev_ce = ce;
            c++;
        end
        idle_inputs();
        ce = 1'b1;
        out_ready = 1'b1;
        chk(0, "stream_count", out_cnt[0] - c0[0], n);
        chk(1, "stream_count", out_cnt[1] - c0[1], n);
    endtask

    function automatic logic signed [15:0] rnd16();
        case ($urandom_range(0, 3))
            0:       return 16'sh7fff;
            1:       return 16'sh8000;
            default: return 16'($urandom);
        endcase
    endfunction

    vec_t tv [8];

    initial begin
        tv[0] = mk(2'b00,    100,    -50,     30,     20,     70,    -70,    70,    -70, 0);
        tv[1] = mk(2'b01,  32767, -32768,      1,     -1,  32768, -32769, 32767, -32768, 1);
        tv[2] = mk(2'b10,      5,      7,     20,     -3,     15,    -10,    15,    -10, 0);
        tv[3] = mk(2'b11,     10,     10,      3,      4,      7,     14,     7,     14, 0);
        tv[4] = mk(2'b00, -32768,      0,  32767,      0, -65535,      0, -32768,     0, 1);
        tv[5] = mk(2'b10, -32768,  32767,  32767, -32768,  65535, -65535, 32767, -32768, 1);
        tv[6] = mk(2'b11,      0, -32768,      0, -32768,      0, -65536,     0, -32768, 1);
        tv[7] = mk(2'b01,     -1,      1,      1,     -1,      0,      0,     0,      0, 0);

        rst = 1'b1; ce = 1'b1; out_ready = 1'b1; ovf_clr = 1'b0;
        for (int d = 0; d < 2; d++) drive(d, 1'b0, 2'b00, 16'sd0, 16'sd0, 16'sd0, 16'sd0);

        // Reset state
        #1;
        for (int d = 0; d < 2; d++) begin
            chk(d, "reset_valid", int'(out_valid_a[d]), 0);
            chk(d, "reset_sr", osr[d], 0);
            chk(d, "reset_si", osi[d], 0);
            chk(d, "reset_ovf", int'(ovf_a[d]), 0);
            chk(d, "reset_ready", int'(in_ready_a[d]), 0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk(0, "ready_after_rst", int'(ir0), 1);
        chk(1, "ready_after_rst", int'(ir1), 1);

        // Table-driven vectors
        for (int k = 0; k < 8; k++) apply_vec(tv[k]);

        // Sticky flag: set, clear, then clear coinciding with a new set
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) drive(d, 1'b1, 2'b01, 16'sh7fff, 16'sh8000, 16'sd1, -16'sd1);
        @(posedge clk); #1;
        idle_inputs();
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk(1, "ovf_sticky", int'(of1), 1);
        chk(0, "ovf_full_prec", int'(of0), 0);
        @(posedge clk); #1; ovf_clr = 1'b1;
        @(posedge clk); #1; ovf_clr = 1'b0;
        @(negedge clk);
        chk(1, "ovf_cleared", int'(of1), 0);
        @(posedge clk); #1;
        drive(1, 1'b1, 2'b01, 16'sh7fff, 16'sh8000, 16'sd1, -16'sd1);
        @(posedge clk); #1;                      // accepted at edge N
        idle_inputs();
        @(posedge clk); @(posedge clk); @(posedge clk); #1;  // out_valid after N+3
        ovf_clr = 1'b1;                          // transfer and clear at N+4
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk(1, "ovf_set_wins", int'(of1), 1);

        // Asynchronous reset with samples in flight
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) drive(d, 1'b1, 2'b00, 16'sd1, 16'sd2, 16'sd3, 16'sd4);
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) drive(d, 1'b1, 2'b01, 16'sd5, 16'sd6, 16'sd7, 16'sd8);
        @(posedge clk); #1;
        idle_inputs();
        chk(0, "pre_rst_valid", int'(ov0), 1);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk(d, "async_rst_valid", int'(out_valid_a[d]), 0);
            chk(d, "async_rst_sr", osr[d], 0);
            chk(d, "async_rst_si", osi[d], 0);
            chk(d, "async_rst_ovf", int'(ovf_a[d]), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk(0, "no_stale_out", int'(ov0), 0);
            chk(1, "no_stale_out", int'(ov1), 0);
        end

        // Stream with downstream stall on cycles 4..7
        stream(10, 4, 7, 1000, 999);
        chk(0, "stall_blocks_input", int'(saw_stall), 1);

        // Stream with ce low for three cycles mid-stream
        stream(10, 1000, 999, 3, 5);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            ce        = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            for (int d = 0; d < 2; d++)
                drive(d, ($urandom_range(0, 2) != 0), 2'($urandom), rnd16(), rnd16(), rnd16(), rnd16());
        end
        @(posedge clk); #1;
        idle_inputs();
        ce = 1'b1; out_ready = 1'b1; ovf_clr = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk(0, "drain_empty", wr[0] - rd[0], 0);
        chk(1, "drain_empty", wr[1] - rd[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
